muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit implementing the RV32M/RV64M operation set alongside the single-cycle integer ALU in the execute stage. It is parametrised in operand width, accepts one operation at a time over a valid/ready handshake, computes over XLEN cycles with one shared adder, and holds the result until the pipeline takes it. Divide-by-zero and signed-overflow cases take a one-cycle fast path. A flush input aborts work in flight.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  abort current operation, discard result
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept (high only in IDLE)
- op  in  3  md_op_t, equal to RV32M funct3
- A  in  XLEN  rs1 operand (multiplicand/dividend)
- B  in  XLEN  rs2 operand (multiplier/divisor)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- div_by_zero  out  1  qualifies result: DIV/DIVU/REM/REMU with B == 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready (and no flush): latch op, take operand magnitudes and result sign, clear counter.
  - Divide ops with B == 0 -> DONE; result = all ones (DIV/DIVU) or A (REM/REMU); div_by_zero = 1.
  - DIV/REM with A = most-negative and B = -1 -> DONE; result = A (DIV) or 0 (REM).
  - Otherwise -> CALC.
- CALC: one step per cycle, XLEN steps, counter 0..XLEN-1.
  - Multiply: shift-add into a 2*XLEN product register over the unsigned magnitudes.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if non-negative.
  - After the last step, apply the sign fix and select the output, then -> DONE.
- Signedness: MUL, MULH signed x signed; MULHSU signed A x unsigned B; MULHU, DIVU, REMU unsigned. Product is negated when the operand signs differ. Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
- Result selection: MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: out_valid = 1, and result and div_by_zero are held stable until out_ready. Transfer happens on out_valid & out_ready, then -> IDLE. No new request is accepted in the transfer cycle.
- flush: from any state -> IDLE on the next edge. out_valid drops and the result is lost. flush overrides both handshakes in the same cycle.
- rst: state IDLE, out_valid 0, result 0, div_by_zero 0, counter 0; in_ready is 1 from the first cycle after reset.

## Timing
- Accept at edge 0.
- Normal operation: CALC occupies cycles 1..XLEN; out_valid rises at cycle XLEN+1 (33 for XLEN=32).
- Fast path: out_valid rises at cycle 1.
- in_ready and out_valid are Moore outputs of state, with no combinational path from inputs.
- Throughput: at most one operation per XLEN+2 cycles; back-to-back requests see in_ready low until IDLE.
- Reset or flush asserted mid-CALC: the next cycle is IDLE with in_ready = 1 and no out_valid pulse.

## Structure
- Shared package muldiv_pkg:
  - md_op_t enum: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7; decode shares it.
  - md_state_t enum: IDLE/CALC/DONE.
- Single module with no sub-module. One XLEN+1-bit adder/subtractor is shared by the multiply and divide datapaths.

## Test plan
- MUL, A=7, B=-3 (XLEN=32) -> out_valid at cycle 33, result 0xFFFFFFEB, div_by_zero 0.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> -3 (0xFFFFFFFD); REM same operands -> -1; DIVU A=100, B=7 -> 14; REMU same operands -> 2.
- DIVU A=5, B=0 -> cycle-1 result 0xFFFFFFFF with div_by_zero=1. REM A=5, B=0 -> 5. DIV A=0x80000000, B=-1 -> 0x80000000 with div_by_zero 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready 0. Then pulse out_ready -> IDLE next cycle.
- flush at cycle 10 of a DIV, and separately rst mid-CALC -> IDLE next cycle, no out_valid. A following MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   md_op_t    - operation code, encoded exactly as the RV32M/RV64M funct3 field
//                so the decoder can pass funct3 straight through.
//   md_state_t - control state of the unit (IDLE, CALC, DONE).
//   Helpers classify an operation as divide, remainder, or signed on A/B.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

  function automatic logic is_div(input md_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input md_op_t op);
    return op inside {REM, REMU};
  endfunction

  function automatic logic a_signed(input md_op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(input md_op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//   One operation at a time: accepted in IDLE over in_valid/in_ready, computed
//   over XLEN cycles (shift-add multiply or restoring divide on operand
//   magnitudes, one shared XLEN+1-bit adder), then held in DONE until
//   out_valid/out_ready transfers it. Divide-by-zero and signed overflow
//   skip CALC and reach DONE after one cycle. flush returns to IDLE from any
//   state and drops any pending result.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - abort current operation
//   in_valid/ready  - request handshake (in_ready high only in IDLE)
//   op, A, B        - operation (funct3), rs1, rs2
//   out_valid/ready - result handshake (out_valid high only in DONE)
//   result          - operation result
//   div_by_zero     - divide/remainder with B == 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_t          op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN);

  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Multiply: {hi, lo} is the product register, lo starts as the multiplier.
  // Divide:   hi is the partial remainder, lo shifts the dividend out and
  //           the quotient in.
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;       // multiplicand or divisor magnitude
  logic            neg_q, neg_d;   // negate the selected result at the end
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  // Operand decode for the request at the input.
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_ovf;

  assign neg_a   = a_signed(op) & A[XLEN-1];
  assign neg_b   = b_signed(op) & B[XLEN-1];
  assign mag_a   = neg_a ? -A : A;
  assign mag_b   = neg_b ? -B : B;
  assign div_ovf = (op inside {DIV, REM}) && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

  // Shared adder/subtractor; bit XLEN+1 is the carry-out, which on a
  // subtract means "no borrow", i.e. the trial remainder is non-negative.
  logic [XLEN:0]   add_a, add_b;
  logic            add_sub;
  logic [XLEN+1:0] add_res;

  assign add_res = {1'b0, add_a} + {1'b0, add_b ^ {(XLEN+1){add_sub}}}
                 + {{(XLEN+1){1'b0}}, add_sub};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  // NOTE: every variable gets a default at the top, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    add_a    = '0;
    add_b    = '0;
    add_sub  = 1'b0;
    prod_s   = '0;
    quo_s    = '0;
    rem_s    = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          cnt_d = '0;
          dbz_d = 1'b0;
          hi_d  = '0;
          lo_d  = is_div(op) ? mag_a : mag_b;
          b_d   = is_div(op) ? mag_b : mag_a;
          neg_d = is_rem(op) ? neg_a : (neg_a ^ neg_b);
          if (is_div(op) && (B == '0)) begin
            state_d  = DONE;
            dbz_d    = 1'b1;
            result_d = is_rem(op) ? A : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = is_rem(op) ? '0 : A;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (is_div(op_q)) begin
          add_a   = {hi_q, lo_q[XLEN-1]};
          add_b   = {1'b0, b_q};
          add_sub = 1'b1;
          hi_d    = add_res[XLEN+1] ? add_res[XLEN-1:0] : add_a[XLEN-1:0];
          lo_d    = {lo_q[XLEN-2:0], add_res[XLEN+1]};
        end else begin
          add_a = {1'b0, hi_q};
          add_b = lo_q[0] ? {1'b0, b_q} : '0;
          hi_d  = add_res[XLEN:1];
          lo_d  = {add_res[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);

        if (cnt_q == CW'(XLEN-1)) begin
          // Sign fix and output select use the final step's values directly.
          prod_s  = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
          quo_s   = neg_q ? -lo_d : lo_d;
          rem_s   = neg_q ? -hi_d : hi_d;
          state_d = DONE;
          unique case (op_q)
            MUL:                  result_d = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU:  result_d = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:            result_d = quo_s;
            REM, REMU:            result_d = rem_s;
          endcase
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // flush wins over both handshakes.
    if (flush) state_d = IDLE;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
